axis_downsize: RTL and testbench
================================

# axis_downsize

Stream width down-converter for the pattern-generator datapath. Each accepted DIN_WIDTH-bit input beat is split into up to RATIO = DIN_WIDTH/DOUT_WIDTH consecutive DOUT_WIDTH-bit output beats, LSB lane first. A run-time lane count trims unused upper lanes. The block sits between a wide AXI-Stream source (FIFO or DMA) and a narrow consumer, and passes TLAST through to the packet's final narrow beat.

## Interface
- DIN_WIDTH, 256: input data width; an integer multiple of DOUT_WIDTH.
- DOUT_WIDTH, 32: output data width.
- RATIO (localparam) = DIN_WIDTH/DOUT_WIDTH; must be ≥ 2. LW = $clog2(RATIO)+1.
- clk  in  1  sole clock; all logic rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- lane_count  in  LW  number of lanes emitted per input beat, 1..RATIO; 0 or >RATIO means RATIO.
- AXIS_RX_TDATA  in  DIN_WIDTH  wide input data.
- AXIS_RX_TLAST  in  1  end of packet on input.
- AXIS_RX_TVALID  in  1  input valid.
- AXIS_RX_TREADY  out  1  input ready.
- AXIS_TX_TDATA  out  DOUT_WIDTH  narrow output data.
- AXIS_TX_TLAST  out  1  end of packet on output.
- AXIS_TX_TVALID  out  1  output valid.
- AXIS_TX_TREADY  in  1  output ready.
- pkt_count  out  32  count of output packets completed (TX TLAST handshakes); wraps at 2^32.

## Operation
- State: hold register (DIN_WIDTH), lane index `lane` (LW), latched lane total `nl`, latched `last`, `full` flag (drives TX_TVALID).
- RX accept (RX_TVALID & RX_TREADY): hold <= RX_TDATA; nl <= sanitised lane_count; last <= RX_TLAST; lane <= 0; full <= 1.
- AXIS_TX_TDATA = hold[lane*DOUT_WIDTH +: DOUT_WIDTH]; AXIS_TX_TVALID = full.
- AXIS_TX_TLAST = full & last & (lane == nl-1). Non-final lanes never carry TLAST.
- TX handshake on a non-final lane: lane <= lane+1.
- TX handshake on the final lane: full <= 0, unless an RX accept occurs in the same cycle, which reloads as above (accept has priority, full stays 1).
- AXIS_RX_TREADY = resetn & (!full | (TX_TREADY & lane == nl-1)). This is a combinational TX_TREADY→RX_TREADY path and is intentional; it gives zero-bubble streaming.
- lane_count is sampled only at RX accept; changes mid-beat have no effect on the beat in flight.
- Upper lanes beyond nl are discarded without emission.
- pkt_count increments by 1 on each cycle with TX_TVALID & TX_TREADY & TX_TLAST.
- Reset (async assert at any time, including mid-beat): full=0, lane=0, nl=RATIO, last=0, hold=0, pkt_count=0. The in-flight beat is dropped. Deassertion is taken synchronously at the next edge.

## Timing
- Reset values: TX_TVALID=0, TX_TLAST=0, TX_TDATA=0, pkt_count=0, RX_TREADY=0 while resetn low; RX_TREADY=1 on the first cycle after release.
- Latency: RX accepted at edge N → TX_TVALID=1 with lane 0 in cycle N+1.
- Throughput: with TX_TREADY held high, one input beat per nl cycles and no idle cycles between beats.
- TX_TDATA/TX_TLAST are stable while TX_TVALID=1 and TX_TREADY=0 (AXI-Stream rule). TX_TVALID never drops without a handshake except on reset.
- nl=1: behaves as a registered slice of lane 0 with full throughput.

## Test plan
- Basic split: RATIO=8, lane_count=8, RX beat {32'h7..0 per lane: lane k = k}, TLAST=1, TX_TREADY=1 → TX emits 0,1,…,7 on 8 consecutive cycles; TLAST only on value 7; pkt_count=1.
- Trim: lane_count=3, two RX beats lanes A0..A7 / B0..B7, TLAST on the second → TX A0,A1,A2,B0,B1,B2 with no gaps; TLAST on B2 only; RX_TREADY high only on cycles TX sends A2/B2 or when empty.
- Backpressure: random TX_TREADY (50%) over 100 beats with lane_count=8 → output sequence equals a reference model; TDATA unchanged during every stall; no lost or duplicated lanes.
- lane_count edge values: 0 → 8 lanes emitted; 9 → 8 lanes; 1 → one lane per beat at one beat/cycle. Changing lane_count from 8 to 2 mid-beat → the current beat still emits 8.
- Reset mid-beat: assert resetn=0 after lane 3 is sent → TX_TVALID=0 immediately (async); after release, the next RX beat starts at lane 0; pkt_count=0.
- Wrap: force pkt_count to 32'hFFFFFFFF, complete one packet → pkt_count=0.

Source files
------------

// File: rtl/axis_downsize.sv
// axis_downsize
// Stream width down-converter. Each accepted wide input beat is held and
// replayed as up to RATIO narrow output beats, least-significant lane first.
// A run-time lane count trims unused upper lanes, and the input TLAST is
// carried only on the final narrow beat of the held word.
//
// Ports:
//   clk              sole clock, rising edge
//   resetn           asynchronous active-low reset
//   lane_count       lanes emitted per input beat (0 or >RATIO means RATIO)
//   AXIS_RX_*        wide AXI-Stream slave (TDATA/TLAST/TVALID in, TREADY out)
//   AXIS_TX_*        narrow AXI-Stream master (TDATA/TLAST/TVALID out, TREADY in)
//   pkt_count        number of completed output packets, wraps at 2^32
module axis_downsize #(
  parameter int DIN_WIDTH  = 256,
  parameter int DOUT_WIDTH = 32,
  localparam int RATIO     = DIN_WIDTH / DOUT_WIDTH,
  localparam int LW        = $clog2(RATIO) + 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [LW-1:0]         lane_count,
  input  logic [DIN_WIDTH-1:0]  AXIS_RX_TDATA,
  input  logic                  AXIS_RX_TLAST,
  input  logic                  AXIS_RX_TVALID,
  output logic                  AXIS_RX_TREADY,
  output logic [DOUT_WIDTH-1:0] AXIS_TX_TDATA,
  output logic                  AXIS_TX_TLAST,
  output logic                  AXIS_TX_TVALID,
  input  logic                  AXIS_TX_TREADY,
  output logic [31:0]           pkt_count
);

  // Index width needed to select one of RATIO lanes.
  localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [DIN_WIDTH-1:0]  r_hold;
  logic [LW-1:0]         r_lane;
  logic [LW-1:0]         r_nl;
  logic                  r_last;
  logic                  r_full;
  logic [31:0]           r_pkt_count;

  logic [LW-1:0]         w_nl_sane;
  logic                  w_final_lane;
  logic                  w_rx_ready;
  logic                  w_rx_accept;
  logic                  w_tx_hs;
  logic [DOUT_WIDTH-1:0] w_lane_data [RATIO];

  // Out-of-range lane counts (zero or above RATIO) fall back to all lanes.
  always_comb begin
    w_nl_sane = lane_count;
    if ((lane_count == '0) || (lane_count > LW'(RATIO)))
      w_nl_sane = LW'(RATIO);
  end

  assign w_final_lane = (r_lane == LW'(r_nl - LW'(1)));

  // Ready looks straight through to TX_TREADY on the final lane so a new
  // wide word can be loaded on the same edge the last narrow beat leaves.
  assign w_rx_ready  = resetn & (~r_full | (AXIS_TX_TREADY & w_final_lane));
  assign w_rx_accept = AXIS_RX_TVALID & w_rx_ready;
  assign w_tx_hs     = r_full & AXIS_TX_TREADY;

  // Lane slices of the held word; the lane index never exceeds RATIO-1, so
  // its low bits are enough to select.
  for (genvar g = 0; g < RATIO; g++) begin : g_lanes
    assign w_lane_data[g] = r_hold[g*DOUT_WIDTH +: DOUT_WIDTH];
  end

  assign AXIS_RX_TREADY = w_rx_ready;
  assign AXIS_TX_TDATA  = w_lane_data[r_lane[IW-1:0]];
  assign AXIS_TX_TVALID = r_full;
  assign AXIS_TX_TLAST  = r_full & r_last & w_final_lane;
  assign pkt_count      = r_pkt_count;

  // Hold register and lane sequencing. A reload on accept takes priority
  // over retiring the final lane, which keeps the stream bubble-free.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hold <= '0;
      r_lane <= '0;
      r_nl   <= LW'(RATIO);
      r_last <= 1'b0;
      r_full <= 1'b0;
    end else if (w_rx_accept) begin
      r_hold <= AXIS_RX_TDATA;
      r_lane <= '0;
      r_nl   <= w_nl_sane;
      r_last <= AXIS_RX_TLAST;
      r_full <= 1'b1;
    end else if (w_tx_hs) begin
      if (w_final_lane)
        r_full <= 1'b0;
      else
        r_lane <= r_lane + LW'(1);
    end
  end

  // Completed-packet counter, stepped on every TLAST handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_pkt_count <= '0;
    else if (w_tx_hs && AXIS_TX_TLAST)
      r_pkt_count <= r_pkt_count + 32'd1;
  end

endmodule

// File: tb/tb_axis_downsize.sv
// tb_axis_downsize
// Scoreboarded bench for axis_downsize (256 -> 32 bits, RATIO 8). The driver
// pushes the expected narrow beats of every wide beat it issues; a monitor on
// the falling edge pops and compares each output handshake and checks that
// stalled output stays stable.
module tb_axis_downsize;

  localparam int DIN   = 256;
  localparam int DOUT  = 32;
  localparam int RATIO = 8;
  localparam int LW    = 4;

  typedef struct packed {
    logic [DOUT-1:0] data;
    logic            last;
  } beat_t;

  logic            clk = 1'b0;
  logic            resetn;
  logic [LW-1:0]   lane_count;
  logic [DIN-1:0]  AXIS_RX_TDATA;
  logic            AXIS_RX_TLAST;
  logic            AXIS_RX_TVALID;
  logic            AXIS_RX_TREADY;
  logic [DOUT-1:0] AXIS_TX_TDATA;
  logic            AXIS_TX_TLAST;
  logic            AXIS_TX_TVALID;
  logic            AXIS_TX_TREADY;
  logic [31:0]     pkt_count;

  beat_t       expQ[$];
  beat_t       expBeat;
  int          errors = 0;
  int          checks = 0;
  int          cycle = 0;
  int          hsCount = 0;
  int          firstHs = 0;
  int          lastHs = 0;
  int          lastAccept = 0;
  int          readyMode = 0;
  logic        stallPending = 1'b0;
  logic [31:0] stallData;
  logic        stallLast;

  axis_downsize #(.DIN_WIDTH(DIN), .DOUT_WIDTH(DOUT)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .lane_count     (lane_count),
    .AXIS_RX_TDATA  (AXIS_RX_TDATA),
    .AXIS_RX_TLAST  (AXIS_RX_TLAST),
    .AXIS_RX_TVALID (AXIS_RX_TVALID),
    .AXIS_RX_TREADY (AXIS_RX_TREADY),
    .AXIS_TX_TDATA  (AXIS_TX_TDATA),
    .AXIS_TX_TLAST  (AXIS_TX_TLAST),
    .AXIS_TX_TVALID (AXIS_TX_TVALID),
    .AXIS_TX_TREADY (AXIS_TX_TREADY),
    .pkt_count      (pkt_count)
  );

  // Free-running clock and a cycle counter used to measure spacing.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Output back-pressure: always ready, or a coin toss per cycle.
  always @(posedge clk) begin
    #1;
    if (readyMode == 1)
      AXIS_TX_TREADY = 1'($urandom_range(0, 1));
    else
      AXIS_TX_TREADY = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: a handshake seen before the rising edge pops one expected beat;
  // a stall must present identical data/last on the next cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      stallPending = 1'b0;
    end else begin
      if (stallPending) begin
        checkOutput("stall_valid", 64'(AXIS_TX_TVALID), 64'd1);
        checkOutput("stall_data", 64'(AXIS_TX_TDATA), 64'(stallData));
        checkOutput("stall_last", 64'(AXIS_TX_TLAST), 64'(stallLast));
        stallPending = 1'b0;
      end
      if (AXIS_TX_TVALID && AXIS_TX_TREADY) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got %0h, expected no beat", AXIS_TX_TDATA);
        end else begin
          expBeat = expQ.pop_front();
          checkOutput("tx_data", 64'(AXIS_TX_TDATA), 64'(expBeat.data));
          checkOutput("tx_last", 64'(AXIS_TX_TLAST), 64'(expBeat.last));
        end
        if (hsCount == 0) firstHs = cycle;
        lastHs = cycle;
        hsCount++;
      end else if (AXIS_TX_TVALID) begin
        stallPending = 1'b1;
        stallData    = AXIS_TX_TDATA;
        stallLast    = AXIS_TX_TLAST;
      end
    end
  end

  // Issue one wide beat and queue the narrow beats it should produce.
  // Entered and left just after a rising edge.
  task automatic applyStimulus(input logic [DIN-1:0] data, input logic last,
                               input logic [LW-1:0] lc);
    int  nl;
    int  t;
    bit  acc;
    beat_t b;
    nl = ((lc == 0) || (int'(lc) > RATIO)) ? RATIO : int'(lc);
    for (int k = 0; k < nl; k++) begin
      b.data = data[k*DOUT +: DOUT];
      b.last = last && (k == nl - 1);
      expQ.push_back(b);
    end
    AXIS_RX_TDATA  = data;
    AXIS_RX_TLAST  = last;
    lane_count     = lc;
    AXIS_RX_TVALID = 1'b1;
    acc = 0;
    t   = 0;
    while (!acc && t < 300) begin
      @(negedge clk);
      if (AXIS_RX_TREADY) begin
        acc = 1;
        lastAccept = cycle;
      end
      @(posedge clk);
      #1;
      t++;
    end
    AXIS_RX_TVALID = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL rx_accept_timeout: got no accept, expected accept");
    end
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while ((expQ.size() != 0 || AXIS_TX_TVALID) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    checkOutput("drain_queue", 64'(expQ.size()), 64'd0);
  endtask

  task automatic markWindow();
    hsCount = 0;
  endtask

  logic [DIN-1:0] d;
  logic [DIN-1:0] dA;
  int             acceptA;
  int             tw;

  initial begin
    resetn         = 1'b0;
    lane_count     = '0;
    AXIS_RX_TDATA  = '0;
    AXIS_RX_TLAST  = 1'b0;
    AXIS_RX_TVALID = 1'b0;
    AXIS_TX_TREADY = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tvalid", 64'(AXIS_TX_TVALID), 64'd0);
    checkOutput("rst_tlast", 64'(AXIS_TX_TLAST), 64'd0);
    checkOutput("rst_tdata", 64'(AXIS_TX_TDATA), 64'd0);
    checkOutput("rst_pkt", 64'(pkt_count), 64'd0);
    checkOutput("rst_rxready", 64'(AXIS_RX_TREADY), 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    checkOutput("rel_rxready", 64'(AXIS_RX_TREADY), 64'd1);
    @(posedge clk);
    #1;

    // Basic split: lane k carries value k, eight back-to-back beats.
    for (int k = 0; k < RATIO; k++) d[k*DOUT +: DOUT] = 32'(k);
    markWindow();
    applyStimulus(d, 1'b1, 4'd8);
    waitDrain();
    checkOutput("basic_beats", 64'(hsCount), 64'd8);
    checkOutput("basic_span", 64'(lastHs - firstHs), 64'd7);
    checkOutput("basic_pkt", 64'(pkt_count), 64'd1);

    // Trim to three lanes across two beats with no gaps.
    for (int k = 0; k < RATIO; k++) dA[k*DOUT +: DOUT] = 32'hA000_0000 + 32'(k);
    for (int k = 0; k < RATIO; k++) d[k*DOUT +: DOUT]  = 32'hB000_0000 + 32'(k);
    markWindow();
    applyStimulus(dA, 1'b0, 4'd3);
    acceptA = lastAccept;
    applyStimulus(d, 1'b1, 4'd3);
    checkOutput("trim_accept_gap", 64'(lastAccept - acceptA), 64'd3);
    waitDrain();
    checkOutput("trim_beats", 64'(hsCount), 64'd6);
    checkOutput("trim_span", 64'(lastHs - firstHs), 64'd5);
    checkOutput("trim_pkt", 64'(pkt_count), 64'd2);

    // Lane count edge values: 0 and 9 both mean all eight lanes.
    for (int k = 0; k < RATIO; k++) d[k*DOUT +: DOUT] = 32'hC0C0_0000 + 32'(k);
    markWindow();
    applyStimulus(d, 1'b1, 4'd0);
    waitDrain();
    checkOutput("lc0_beats", 64'(hsCount), 64'd8);
    for (int k = 0; k < RATIO; k++) d[k*DOUT +: DOUT] = 32'hD9D9_0000 + 32'(k);
    markWindow();
    applyStimulus(d, 1'b1, 4'd9);
    waitDrain();
    checkOutput("lc9_beats", 64'(hsCount), 64'd8);

    // One lane per beat at one beat per cycle.
    markWindow();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < RATIO; k++) d[k*DOUT +: DOUT] = 32'h1100_0000 + 32'(i * 16 + k);
      applyStimulus(d, (i == 3), 4'd1);
    end
    waitDrain();
    checkOutput("lc1_beats", 64'(hsCount), 64'd4);
    checkOutput("lc1_span", 64'(lastHs - firstHs), 64'd3);
    checkOutput("lc1_pkt", 64'(pkt_count), 64'd5);

    // Lane count change while a beat is in flight does not affect it.
    for (int k = 0; k < RATIO; k++) d[k*DOUT +: DOUT] = 32'hE000_0000 + 32'(k);
    markWindow();
    applyStimulus(d, 1'b1, 4'd8);
    lane_count = 4'd2;
    waitDrain();
    checkOutput("midchg_beats", 64'(hsCount), 64'd8);
    checkOutput("midchg_pkt", 64'(pkt_count), 64'd6);

    // Random back-pressure over 100 beats, a packet every ten beats.
    readyMode = 1;
    for (int i = 0; i < 100; i++) begin
      for (int k = 0; k < RATIO; k++) d[k*DOUT +: DOUT] = $urandom;
      applyStimulus(d, (i % 10 == 9), 4'd8);
    end
    waitDrain();
    readyMode = 0;
    checkOutput("bp_pkt", 64'(pkt_count), 64'd16);
    @(posedge clk);
    #1;

    // Asynchronous reset after lane 3 has been sent.
    for (int k = 0; k < RATIO; k++) d[k*DOUT +: DOUT] = 32'h5E50_0000 + 32'(k);
    markWindow();
    applyStimulus(d, 1'b1, 4'd8);
    tw = 0;
    while (hsCount < 4 && tw < 50) begin
      @(posedge clk);
      #1;
      tw++;
    end
    checkOutput("rstmid_wait", 64'(hsCount), 64'd4);
    #2 resetn = 1'b0;
    #1;
    checkOutput("rstmid_tvalid", 64'(AXIS_TX_TVALID), 64'd0);
    checkOutput("rstmid_pkt", 64'(pkt_count), 64'd0);
    checkOutput("rstmid_rxready", 64'(AXIS_RX_TREADY), 64'd0);
    expQ.delete();
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int k = 0; k < RATIO; k++) d[k*DOUT +: DOUT] = 32'hF1F1_0000 + 32'(k);
    markWindow();
    applyStimulus(d, 1'b1, 4'd8);
    waitDrain();
    checkOutput("rstmid_after_beats", 64'(hsCount), 64'd8);
    checkOutput("rstmid_after_pkt", 64'(pkt_count), 64'd1);

    // Packet counter wrap.
    @(negedge clk);
    force dut.r_pkt_count = 32'hFFFF_FFFF;
    #1 release dut.r_pkt_count;
    checkOutput("wrap_preset", 64'(pkt_count), 64'hFFFF_FFFF);
    @(posedge clk);
    #1;
    for (int k = 0; k < RATIO; k++) d[k*DOUT +: DOUT] = 32'h7777_0000 + 32'(k);
    applyStimulus(d, 1'b1, 4'd1);
    waitDrain();
    checkOutput("wrap_pkt", 64'(pkt_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
